// File: rtl/router_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : router_packet_arbiter
// Purpose  : Packet-lock round-robin arbiter for one router output port,
//            with a flit-count watchdog that forces release.
// Revision : 1.0
// ============================================================================
module router_packet_arbiter #(
  parameter int FLIT_MAX = 16,
  parameter int CW       = $clog2(FLIT_MAX + 1)
) (
  input  logic          CLK,
  input  logic          _RESET,
  input  logic [1:0]    req,
  input  logic [1:0]    tail,
  input  logic          xfer,
  output logic [1:0]    grant,
  output logic          locked,
  output logic [CW-1:0] flit_cnt,
  output logic          err
);

  localparam logic [1:0]    S_IDLE = 2'd0;
  localparam logic [1:0]    S_OWN0 = 2'd1;
  localparam logic [1:0]    S_OWN1 = 2'd2;
  localparam logic [CW-1:0] C_MAX  = CW'(FLIT_MAX);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          err_q, err_d;

  logic          w_owner;
  logic          w_tail;
  logic [CW-1:0] w_inc;
  logic          w_wdog;
  logic          w_rel;

  // Both requesting: the source that did not own most recently wins.
  function automatic logic [1:0] pick(input logic [1:0] r, input logic l);
    logic [1:0] s;
    case (r)
      2'b01:   s = S_OWN0;
      2'b10:   s = S_OWN1;
      2'b11:   s = l ? S_OWN0 : S_OWN1;
      default: s = S_IDLE;
    endcase
    return s;
  endfunction

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    w_owner = (state_q == S_OWN1);
    w_tail  = tail[w_owner];
    w_inc   = (cnt_q == C_MAX) ? cnt_q : cnt_q + CW'(1);
    w_wdog  = (w_inc == C_MAX);
    w_rel   = (state_q != S_IDLE) && xfer && (w_tail || w_wdog);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: state_d = pick(req, last_q);
      S_OWN0, S_OWN1: begin
        if (xfer) begin
          cnt_d = w_inc;
          if (w_rel) begin
            state_d = pick(req, w_owner);
            if (w_wdog && !w_tail) err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A fresh ownership starts a new packet count and moves the pointer.
    if ((state_d != S_IDLE) && ((state_q == S_IDLE) || w_rel)) begin
      cnt_d  = '0;
      last_d = (state_d == S_OWN1);
    end
  end

  always_comb begin
    grant    = {state_q == S_OWN1, state_q == S_OWN0};
    locked   = (state_q != S_IDLE);
    flit_cnt = cnt_q;
    err      = err_q;
  end

endmodule
`default_nettype wire

// File: doc/router_packet_arbiter.md
# router_packet_arbiter

Clocked packet-lock arbiter for one router output port. It consumes the per-source select requests produced by the router's decode/split stage and drives the one-hot select (`grant`) that the output merge stage uses. A grant is held for an entire packet (header through tail flit), and ownership alternates round-robin between the two competing sources. A flit-count watchdog forces release if a tail never arrives. One instance serves each output (parent, child 1, child 2).

## Interface
- `FLIT_MAX`, default 16: maximum flits per packet. Reaching it without a tail forces release and sets `err`.
- `CW`, default `$clog2(FLIT_MAX+1)`: width of the flit counter.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `_RESET`  in  1  synchronous, active-low reset.
- `req`  in  2  `req[i]` = source i has a flit pending for this output (from the split stage's select rail).
- `tail`  in  2  `tail[i]` = the flit source i presents is the last of its packet. Only meaningful while `req[i]`.
- `xfer`  in  1  merge stage accepted one flit from the currently granted source this cycle.
- `grant`  out  2  one-hot select to the merge stage; `2'b00` = no owner.
- `locked`  out  1  a packet currently owns the output.
- `flit_cnt`  out  CW  flits transferred in the current packet.
- `err`  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- FSM states: IDLE, OWN0, OWN1. `grant` = {OWN1, OWN0}, registered. `locked` = (state != IDLE).
- Round-robin pointer `last` (1 bit) records the most recently granted source.
- Arbitration function `pick(req, last)`:
  - one requester: that requester wins;
  - both requesting: `!last` wins;
  - none: IDLE.
- IDLE: next state = `pick(req, last)`. On entering OWNi: `last <= i`, `flit_cnt <= 0`.
- OWNi, `xfer`=0: hold the state. `req[i]` dropping without a tail does not release the output.
- OWNi, `xfer`=1: `flit_cnt` increments, saturating at `FLIT_MAX`.
- Release condition, evaluated in OWNi with `xfer`=1: `tail[i]`=1, or the incremented count equals `FLIT_MAX`.
- Watchdog release: if the count reaches `FLIT_MAX` with `tail[i]`=0, set `err`.
- On release, the next state is `pick(req, i)`. The other source therefore wins if it is requesting, giving back-to-back packets with no idle cycle. Source i re-owns only if it alone requests. If nobody requests, go to IDLE.
- `xfer` in IDLE is ignored: no count change and no error.
- `req`/`tail` are sampled only at clock edges. No combinational path from any input to any output.

## Timing
- Reset (`_RESET`=0 at an edge) puts state in IDLE and sets:
  - `grant`=00, `locked`=0, `flit_cnt`=0, `err`=0;
  - `last`=1, so source 0 wins the first contention.
- Reset mid-packet: the grant drops at the first reset edge. There is no tail handshake and no partial-packet recovery.
- Grant latency: a `req` sampled at edge t in IDLE gives `grant` valid after edge t (visible in cycle t+1).
- Handover latency: a tail `xfer` sampled at edge t gives the new owner's `grant` visible in cycle t+1. `grant` is never two-hot and never 00 between back-to-back owners.
- Single-flit packet (header is the tail): one owned cycle minimum.
- `flit_cnt` updates on the same edge that samples `xfer`.
- Steady-state throughput: one flit per cycle. Arbitration overhead: 0 cycles on handover, 1 cycle from IDLE.

## Test plan
- Reset, then hold `req`=00 for 5 cycles -> `grant`=00, `locked`=0, `flit_cnt`=0, `err`=0 throughout.
- `req`=01, 3 `xfer` with `tail[0]` on the third -> `grant`=01 from cycle 1, `flit_cnt` 1,2 then release; `grant`=00 the cycle after the tail.
- `req`=11 held, each packet 2 flits -> grants alternate 01,10,01,10. The first grant is 01, and handover has no 00 gap.
- `FLIT_MAX`=4, `req`=10, 4 `xfer` with `tail`=0 -> `grant`=10 for 4 transfers, then release, and `err`=1 stays set until reset.
- OWN0 after 2 of 5 flits, assert `_RESET`=0 for one edge -> `grant`=00, `flit_cnt`=0, `err`=0 next cycle. With `req`=11 afterwards, `grant`=01.
- `xfer` pulses in IDLE with `req`=00, then `req`=01 owned with `xfer`=0 for 6 cycles -> `flit_cnt` stays 0 and `grant`=01 is held, with no release.
